// File: rtl/rf_debug_port.sv
// rf_debug_port: bulk dump/load initiator for the pipeline register file.
// Dump streams every register out in order; load fills every register from a stream.
module rf_debug_port #(
   parameter int NREGS  = 8,
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Start,
   input  logic              Mode,
   output logic              Busy,
   output logic              Done,
   output logic              Core_stall,
   output logic [DATA_W-1:0] Out_data,
   output logic              Out_valid,
   input  logic              Out_ready,
   input  logic [DATA_W-1:0] In_data,
   input  logic              In_valid,
   output logic              In_ready,
   output logic [ADDR_W-1:0] Rf_raddr,
   input  logic [DATA_W-1:0] Rf_rdata,
   output logic              Rf_we,
   output logic [ADDR_W-1:0] Rf_waddr,
   output logic [DATA_W-1:0] Rf_wdata
);
   typedef enum logic [2:0] {IDLE, RD, SEND, LOAD, FLUSH, DONE} state_t;
   state_t              r_state, w_next;
   logic [ADDR_W-1:0]   r_idx, w_idx;
   logic                w_last, w_in_hs;
   logic                w_busy, w_done, w_out_valid, w_in_ready, w_rf_we;
   logic [DATA_W-1:0]   w_out_data, w_rf_wdata;
   logic [ADDR_W-1:0]   w_rf_waddr;
   assign w_last     = r_idx == ADDR_W'(NREGS - 1);
   assign w_in_hs    = r_state == LOAD && In_valid && In_ready;
   assign Rf_raddr   = r_idx;
   assign Core_stall = Busy;
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_state   <= IDLE;
         r_idx     <= '0;
         Busy      <= 1'b0;
         Done      <= 1'b0;
         Out_valid <= 1'b0;
         Out_data  <= '0;
         In_ready  <= 1'b0;
         Rf_we     <= 1'b0;
         Rf_waddr  <= '0;
         Rf_wdata  <= '0;
      end else begin
         r_state   <= w_next;
         r_idx     <= w_idx;
         Busy      <= w_busy;
         Done      <= w_done;
         Out_valid <= w_out_valid;
         Out_data  <= w_out_data;
         In_ready  <= w_in_ready;
         Rf_we     <= w_rf_we;
         Rf_waddr  <= w_rf_waddr;
         Rf_wdata  <= w_rf_wdata;
      end
   end
   always_comb begin
      w_next = r_state;
      w_idx  = r_idx;
      case (r_state)
         IDLE:    if (Start) begin
                     w_next = Mode ? LOAD : RD;
                     w_idx  = '0;
                  end
         RD:      w_next = SEND;
         SEND:    if (Out_ready) begin
                     w_next = w_last ? DONE : RD;
                     w_idx  = w_last ? r_idx : r_idx + 1'b1;
                  end
         LOAD:    if (w_in_hs) begin
                     w_next = w_last ? FLUSH : LOAD;
                     w_idx  = w_last ? r_idx : r_idx + 1'b1;
                  end
         FLUSH:   w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end
   // Outputs are registered: compute their next values from the next state.
   always_comb begin
      w_busy      = w_next != IDLE;
      w_done      = w_next == DONE;
      w_out_valid = w_next == SEND;
      w_in_ready  = w_next == LOAD;
      w_out_data  = r_state == RD ? Rf_rdata : Out_data;
      w_rf_we     = w_in_hs;
      w_rf_waddr  = w_in_hs ? r_idx : Rf_waddr;
      w_rf_wdata  = w_in_hs ? In_data : Rf_wdata;
   end
endmodule

// File: tb/tb_rf_debug_port.sv
// tb_rf_debug_port: randomized self-checking bench for rf_debug_port with a
// behavioural register file and expected-sequence model.
module tb_rf_debug_port;
   logic       Clk = 0, Rst = 1, Start = 0, Mode = 0, Out_ready = 0, In_valid = 0;
   logic [7:0] In_data = 0, Rf_rdata, Out_data, Rf_wdata;
   logic       Busy, Done, Core_stall, Out_valid, In_ready, Rf_we;
   logic [2:0] Rf_raddr, Rf_waddr;
   logic       pre_we = 0;
   logic [2:0] pre_a = 0;
   logic [7:0] pre_d = 0;
   logic [7:0] rf [8];
   int         checks = 0, errors = 0;

   rf_debug_port #(.NREGS(8), .ADDR_W(3), .DATA_W(8)) dut (
      .Clk(Clk), .Rst(Rst), .Start(Start), .Mode(Mode), .Busy(Busy), .Done(Done),
      .Core_stall(Core_stall), .Out_data(Out_data), .Out_valid(Out_valid),
      .Out_ready(Out_ready), .In_data(In_data), .In_valid(In_valid), .In_ready(In_ready),
      .Rf_raddr(Rf_raddr), .Rf_rdata(Rf_rdata), .Rf_we(Rf_we), .Rf_waddr(Rf_waddr),
      .Rf_wdata(Rf_wdata)
   );

   always #5 Clk = ~Clk;
   // Register file: DUT write port, plus a bench-only port used for preloading while idle.
   always @(posedge Clk)
      if (Rf_we) rf[Rf_waddr] <= Rf_wdata;
      else if (pre_we) rf[pre_a] <= pre_d;
   assign Rf_rdata = rf[Rf_raddr];

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic preload(input logic [7:0] v [8]);
      for (int i = 0; i < 8; i++) begin
         pre_we = 1; pre_a = 3'(i); pre_d = v[i];
         tick();
      end
      pre_we = 0;
   endtask

   task automatic check_idle_outputs(input string tag);
      checks++;
      if ({Busy, Done, Core_stall, Out_valid, In_ready, Rf_we} !== 6'b0) begin
         errors++;
         $display("FAIL %s flags got %b exp 000000", tag, {Busy, Done, Core_stall, Out_valid, In_ready, Rf_we});
      end
      checks++;
      if (Out_data !== 8'h0 || Rf_wdata !== 8'h0) begin
         errors++;
         $display("FAIL %s data got out=%h wdata=%h exp 00/00", tag, Out_data, Rf_wdata);
      end
      checks++;
      if (Rf_waddr !== 3'h0 || Rf_raddr !== 3'h0) begin
         errors++;
         $display("FAIL %s addr got waddr=%h raddr=%h exp 0/0", tag, Rf_waddr, Rf_raddr);
      end
   endtask

   task automatic test_reset();
      Rst = 1;
      tick(); tick();
      check_idle_outputs("reset");
      Rst = 0;
      tick();
      check_idle_outputs("post_reset_idle");
   endtask

   task automatic test_dump_basic();
      logic [7:0] v [8];
      bit         vld;
      for (int i = 0; i < 8; i++) v[i] = 8'h10 + 8'(i);
      preload(v);
      Out_ready = 1; Mode = 0; Start = 1;
      tick();
      Start = 0;
      for (int n = 0; n <= 17; n++) begin
         vld = (n % 2 == 1) && n <= 15;
         checks++;
         if (Busy !== 1'(n <= 16) || Core_stall !== 1'(n <= 16)) begin
            errors++;
            $display("FAIL dump_basic_busy n=%0d got %b/%b exp %b", n, Busy, Core_stall, n <= 16);
         end
         checks++;
         if (Out_valid !== vld) begin
            errors++;
            $display("FAIL dump_basic_valid n=%0d got %b exp %b", n, Out_valid, vld);
         end
         checks++;
         if (Done !== 1'(n == 16)) begin
            errors++;
            $display("FAIL dump_basic_done n=%0d got %b exp %b", n, Done, n == 16);
         end
         if (vld) begin
            checks++;
            if (Out_data !== 8'h10 + 8'((n - 1) / 2)) begin
               errors++;
               $display("FAIL dump_basic_data n=%0d got %h exp %h", n, Out_data, 8'h10 + 8'((n - 1) / 2));
            end
         end
         tick();
      end
      Out_ready = 0;
   endtask

   task automatic test_dump(input bit bp, input bit noisy, input bit do_pre);
      logic [7:0] e [8];
      logic [7:0] got [$];
      logic [7:0] pd = 0;
      int         c = 0, dones = 0, wes = 0, stall = 0;
      bit         pv = 0, pr = 0;
      if (do_pre) begin
         for (int i = 0; i < 8; i++) e[i] = bp ? 8'h10 + 8'(i) : 8'($urandom);
         preload(e);
      end else
         for (int i = 0; i < 8; i++) e[i] = rf[i];
      Mode = 0; Start = 1;
      tick();
      Start = 0;
      while (Busy === 1'b1 && c < 300) begin
         if (pv && !pr) begin
            checks++;
            if (Out_valid !== 1'b1 || Out_data !== pd) begin
               errors++;
               $display("FAIL dump_hold got v=%b d=%h exp v=1 d=%h", Out_valid, Out_data, pd);
            end
         end
         if (noisy) begin
            Start = 1'($urandom_range(0, 1));
            Mode  = 1'($urandom_range(0, 1));
         end
         Out_ready = bp ? 1'(!(Out_valid === 1'b1 && got.size() == 3 && stall < 5))
                        : (noisy ? 1'($urandom_range(0, 1)) : 1'b1);
         if (bp && !Out_ready) stall++;
         if (Out_valid === 1'b1 && Out_ready) got.push_back(Out_data);
         if (Done === 1'b1) dones++;
         if (Rf_we !== 1'b0) wes++;
         pv = Out_valid; pr = Out_ready; pd = Out_data;
         tick();
         c++;
      end
      Start = 0; Out_ready = 0;
      checks++;
      if (c >= 300) begin errors++; $display("FAIL dump_timeout got %0d cycles exp <300", c); end
      checks++;
      if (dones != 1) begin errors++; $display("FAIL dump_done_count got %0d exp 1", dones); end
      checks++;
      if (wes != 0) begin errors++; $display("FAIL dump_write_port got %0d writes exp 0", wes); end
      checks++;
      if (got.size() != 8) begin errors++; $display("FAIL dump_word_count got %0d exp 8", got.size()); end
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== e[i]) begin
            errors++;
            $display("FAIL dump_word%0d got %h exp %h", i, got[i], e[i]);
         end
      end
      if (bp) begin
         checks++;
         if (stall != 5) begin errors++; $display("FAIL dump_stall_len got %0d exp 5", stall); end
      end
      tick();
      checks++;
      if (Busy !== 1'b0) begin errors++; $display("FAIL dump_back_idle got %b exp 0", Busy); end
   endtask

   task automatic test_load(input bit gaps, input bit noisy);
      logic [7:0] d [8];
      int         k = 0, w = 0, c = 0, dones = 0, gap = 0, first = -1, last = -1;
      bit         piv = 1;
      for (int i = 0; i < 8; i++) d[i] = (gaps || noisy) ? 8'($urandom) : 8'hA0 + 8'(i);
      Mode = 1; Start = 1;
      tick();
      Start = 0;
      checks++;
      if (In_ready !== 1'b1 || Busy !== 1'b1) begin
         errors++;
         $display("FAIL load_entry got rdy=%b busy=%b exp 1/1", In_ready, Busy);
      end
      while (Busy === 1'b1 && c < 300) begin
         if (!piv && k < 8) begin
            checks++;
            if (Rf_we !== 1'b0 || In_ready !== 1'b1) begin
               errors++;
               $display("FAIL load_gap got we=%b rdy=%b exp 0/1", Rf_we, In_ready);
            end
         end
         if (Rf_we === 1'b1) begin
            checks++;
            if (w >= 8) begin
               errors++;
               $display("FAIL load_extra_write got %0d exp 8", w + 1);
            end else if (Rf_waddr !== 3'(w) || Rf_wdata !== d[w]) begin
               errors++;
               $display("FAIL load_write%0d got %h:%h exp %h:%h", w, Rf_waddr, Rf_wdata, 3'(w), d[w]);
            end
            if (first < 0) first = c;
            last = c;
            w++;
         end
         if (noisy) begin
            Start = 1'($urandom_range(0, 1));
            Mode  = 1'($urandom_range(0, 1));
         end
         In_valid = k < 8 && (gaps ? !(k == 3 && gap < 3) : (noisy ? 1'($urandom_range(0, 1)) : 1'b1));
         if (gaps && k == 3 && gap < 3) gap++;
         In_data = d[k < 8 ? k : 7];
         if (In_valid && In_ready === 1'b1) k++;
         piv = In_valid;
         if (Done === 1'b1) dones++;
         tick();
         c++;
      end
      Start = 0; In_valid = 0;
      checks++;
      if (c >= 300) begin errors++; $display("FAIL load_timeout got %0d cycles exp <300", c); end
      checks++;
      if (dones != 1) begin errors++; $display("FAIL load_done_count got %0d exp 1", dones); end
      checks++;
      if (w != 8 || k != 8) begin errors++; $display("FAIL load_counts got w=%0d k=%0d exp 8/8", w, k); end
      if (!gaps && !noisy) begin
         checks++;
         if (last - first != 7) begin
            errors++;
            $display("FAIL load_consecutive got span %0d exp 7", last - first);
         end
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (rf[i] !== d[i]) begin errors++; $display("FAIL load_rf%0d got %h exp %h", i, rf[i], d[i]); end
      end
      tick();
      checks++;
      if (Busy !== 1'b0) begin errors++; $display("FAIL load_back_idle got %b exp 0", Busy); end
   endtask

   task automatic test_reset_mid_load();
      logic [7:0] old [8], d [8];
      int         k = 0, c = 0, dones = 0;
      for (int i = 0; i < 8; i++) begin
         old[i] = 8'($urandom);
         d[i]   = 8'($urandom);
      end
      preload(old);
      Mode = 1; Start = 1;
      tick();
      Start = 0;
      while (k < 4 && c < 50) begin
         In_valid = 1; In_data = d[k];
         if (In_ready === 1'b1) k++;
         if (Done === 1'b1) dones++;
         tick();
         c++;
      end
      Rst = 1; In_valid = 1; In_data = d[4];
      tick();
      Rst = 0; In_valid = 0;
      check_idle_outputs("midload_reset");
      for (int i = 0; i < 3; i++) begin
         tick();
         if (Done === 1'b1 || Busy === 1'b1) dones++;
      end
      checks++;
      if (dones != 0 || k != 4) begin
         errors++;
         $display("FAIL midload_no_done got done=%0d k=%0d exp 0/4", dones, k);
      end
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (rf[i] !== (i < 4 ? d[i] : old[i])) begin
            errors++;
            $display("FAIL midload_rf%0d got %h exp %h", i, rf[i], i < 4 ? d[i] : old[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_dump_basic();
      test_dump(1'b1, 1'b0, 1'b1);
      test_dump(1'b0, 1'b1, 1'b1);
      test_load(1'b0, 1'b0);
      test_dump(1'b0, 1'b0, 1'b0);
      test_load(1'b1, 1'b0);
      test_load(1'b0, 1'b1);
      test_dump(1'b0, 1'b1, 1'b0);
      test_reset_mid_load();
      test_dump(1'b0, 1'b0, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rf_debug_port.md
# rf_debug_port

Debug/bulk-access initiator for the 8 x 8-bit pipeline register file. On command it either dumps all registers, in order, onto a valid/ready output stream (dump mode) or fills all registers from a valid/ready input stream (load mode). It drives the register file's write port and one read port. While active it asserts `Core_stall` so the pipeline leaves the register file alone.

## Interface
- `NREGS`, 8: number of registers transferred per command; a power of two, at least 2.
- `ADDR_W`, 3: register address width; equals log2(`NREGS`).
- `DATA_W`, 8: register data width.

- `Clk` input 1: single clock; everything updates on the rising edge.
- `Rst` input 1: synchronous, active-high reset.
- `Start` input 1: command strobe; sampled only in IDLE.
- `Mode` input 1: 0 = dump, 1 = load; sampled together with `Start`.
- `Busy` output 1: high in every state except IDLE.
- `Done` output 1: one-cycle pulse when a command completes.
- `Core_stall` output 1: equal to `Busy`.
- `Out_data` output `DATA_W`: dump stream data.
- `Out_valid` output 1: dump stream valid.
- `Out_ready` input 1: dump stream ready.
- `In_data` input `DATA_W`: load stream data.
- `In_valid` input 1: load stream valid.
- `In_ready` output 1: load stream ready.
- `Rf_raddr` output `ADDR_W`: register-file read address; equal to the index counter.
- `Rf_rdata` input `DATA_W`: register-file read data, combinational from `Rf_raddr`.
- `Rf_we` output 1: register-file write enable, registered.
- `Rf_waddr` output `ADDR_W`: register-file write address, registered.
- `Rf_wdata` output `DATA_W`: register-file write data, registered.

## Operation
- **States:** IDLE, RD, SEND, LOAD, FLUSH, DONE. The FSM holds an index counter `idx` of width `ADDR_W`.
- **Reset:** state = IDLE and `idx` = 0.
  - Outputs go to 0: `Busy`, `Done`, `Out_valid`, `Out_data`, `In_ready`, `Rf_we`, `Rf_waddr`, `Rf_wdata`.
  - `Rf_raddr` = 0.
  - Reset mid-command aborts immediately. No further write occurs after the reset edge. Any partially loaded registers keep their contents.
- **IDLE:**
  - `Start`=1 with `Mode`=0 → RD, `idx`=0.
  - `Start`=1 with `Mode`=1 → LOAD, `idx`=0.
  - `Start` is ignored in all other states.
- **RD** (dump):
  - `Rf_raddr`=`idx`.
  - At the edge: `Out_data`<=`Rf_rdata`, `Out_valid`<=1, → SEND.
- **SEND:**
  - Hold `Out_data` and `Out_valid` until `Out_ready`=1. `Out_valid` never drops without a handshake.
  - On handshake: `Out_valid`<=0.
    - If `idx`=`NREGS`-1 → DONE.
    - Otherwise `idx`++ and → RD.
- **LOAD:**
  - `In_ready`=1, registered; it goes high on entry to LOAD.
  - On each `In_valid`&&`In_ready` edge: `Rf_we`<=1, `Rf_waddr`<=`idx`, `Rf_wdata`<=`In_data`.
    - If `idx`=`NREGS`-1 → FLUSH, with `In_ready`<=0.
    - Otherwise `idx`++.
  - An edge with no handshake sets `Rf_we`<=0.
  - Back-to-back accepts are allowed, one word per cycle.
- **FLUSH:** `Rf_we` stays high for the final write; the register file commits it at this edge. At the edge: `Rf_we`<=0 and → DONE.
- **DONE:** `Done`=1 for exactly one cycle, then → IDLE. `Busy` stays high in DONE.
- **Index wrap:** `idx` never wraps during a command; it is cleared to 0 on every command start.
- **Port usage:** the write port is never touched in dump mode, and the read address is don't-care in load mode.

## Timing
- **Dump, Start to first valid:** `Start` at edge E0, then `Out_valid`=1 after E1 (RD occupies E0→E1). Latency is 2 edges.
- **Dump throughput:** 2 cycles per word with `Out_ready` tied high. A full dump of 8 words takes 16 cycles from E0 to entry into DONE, with `Done` high in cycle 17.
- **Load write latency:** a word accepted at edge E is presented on the `Rf_*` outputs after E and committed to the register file at E+1.
- **Load total:** with `In_valid` held high, LOAD lasts 8 cycles, then 1 FLUSH cycle, then 1 DONE cycle.
- **Outputs:** all outputs are registered except `Rf_raddr`, which is driven directly from the registered `idx`.
- **Start during DONE:** ignored. A new command is accepted only in the IDLE cycle that follows.

## Test plan
- **Dump basic:** preload registers r0..r7 = 0x10..0x17, `Out_ready`=1, pulse `Start` with `Mode`=0.
  - Required: `Out_data` sequence 0x10..0x17, each word valid 1 cycle apart every 2 cycles.
  - Required: one `Done` pulse, and `Busy` high from E0 through DONE.
- **Dump backpressure:** hold `Out_ready`=0 for 5 cycles on word 3 (value 0x13).
  - Required: `Out_data`=0x13 stable and `Out_valid` high throughout.
  - Required: no word skipped or duplicated.
- **Load basic:** pulse `Start` with `Mode`=1, stream 0xA0..0xA7 with `In_valid`=1 continuously.
  - Required: 8 `Rf_we` pulses on consecutive cycles with `Rf_waddr` 0..7.
  - Required: after `Done`, a register-file readback gives r0..r7 = 0xA0..0xA7.
- **Load gaps:** deassert `In_valid` for 3 cycles after word 2.
  - Required: `Rf_we`=0 during the gap, `In_ready` stays 1, and final contents are correct.
- **Reset mid-load:** assert `Rst` after 4 words have been accepted.
  - Required: r0..r3 = new data and r4..r7 unchanged.
  - Required: all outputs at their reset values on the next cycle, and no `Done` pulse.
- **Ignored Start:** pulse `Start` in RD, SEND, LOAD and DONE.
  - Required: no effect. The running command completes normally, and only one `Done` pulse occurs.
